int_issue_queue: RTL and testbench
==================================

Name: int_issue_queue

Overview:
- Integer reservation station / issue queue directly downstream of the dispatcher.
- Accepts one dispatched integer instruction per cycle, carrying operand values or producer tags.
- Snoops the CDB to wake up pending operands.
- Issues the oldest entry with both operands ready to the integer ALU through a valid/ready handshake.

Parameters:
DEPTH, 4, number of queue entries (power of two, 2..16)
TAG_W, 6, ROB/producer tag width (matches cdb_tag)
DATA_W, 32, operand width
OP_W, 4, ALU operation code width

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_flush  input  1  clear all entries (branch mispredict recovery)
dispatch_en  input  1  write a new entry this cycle
dispatch_op  input  OP_W  ALU operation
dispatch_rs1_data  input  DATA_W  rs1 value, meaningful when rs1_valid=1
dispatch_rs1_tag  input  TAG_W  rs1 producer tag when rs1_valid=0
dispatch_rs1_valid  input  1  rs1 value already available
dispatch_rs2_data  input  DATA_W  rs2 value
dispatch_rs2_tag  input  TAG_W  rs2 producer tag
dispatch_rs2_valid  input  1  rs2 value already available
dispatch_rd_tag  input  TAG_W  destination tag of the instruction
full  output  1  queue holds DEPTH entries; dispatcher must stall
cdb_tag  input  TAG_W  broadcast tag
cdb_valid  input  1  broadcast valid
cdb_data  input  DATA_W  broadcast result
issue_valid  output  1  an issuable entry is presented
issue_ready  input  1  ALU accepts this cycle
issue_op  output  OP_W  op of the presented entry
issue_rs1  output  DATA_W  rs1 operand
issue_rs2  output  DATA_W  rs2 operand
issue_rd_tag  output  TAG_W  destination tag

Behaviour:
- Reset (i_rst=1 at a clock edge): all entry valid bits cleared and count=0.
  - Outputs then read full=0, issue_valid=0, issue_op/issue_rs1/issue_rs2/issue_rd_tag=0.
  - Reset has priority over flush, dispatch, issue and wakeup.
- Storage: compacting queue. Index 0 is the oldest entry.
  - Each entry holds: valid, op, rs1 {rdy, tag, data}, rs2 {rdy, tag, data}, rd_tag.
- full = (count == DEPTH), registered state, no combinational path from dispatch_en.
- Dispatch: if dispatch_en && !full, the new entry is written at position count minus (1 if an issue handshake occurs this cycle).
  - Dispatch while full is ignored with no state change. The dispatcher is responsible for stalling.
  - A dispatch in the same cycle as an issue when full=1 is still rejected.
- Dispatch-time CDB bypass: if cdb_valid, rsN_valid=0 and cdb_tag==rsN_tag in the same cycle, the operand is written ready with cdb_data.
- Wakeup: each cycle with cdb_valid=1, every valid entry whose rsN is not ready and whose tag equals cdb_tag captures cdb_data and sets rdy.
  - Both operands may wake on the same broadcast.
  - An entry woken at edge N can issue in the cycle after edge N.
  - The CDB value is not forwarded combinationally to the issue outputs.
- Issue selection (combinational from registered state): the lowest-index valid entry with both rdy=1.
  - issue_valid=1 when such an entry exists, and issue_* show its fields.
  - When issue_valid=0, issue_* are driven to 0.
- Handshake: on issue_valid && issue_ready at an edge:
  - the selected entry is removed;
  - entries above it shift down by one, preserving age order;
  - count decrements.
  - Outputs must remain stable while issue_valid=1 and issue_ready=0, unless an older entry becomes ready.
- Simultaneous wakeup and shift: a CDB wakeup applies to the entry at its post-shift position. No wakeup is lost.
- Simultaneous dispatch and issue: count is unchanged. The new entry lands at the youngest slot after the shift.
- Flush (i_flush=1): all entries invalidated and count=0. Any dispatch in the same cycle is discarded.
  - issue_valid reads 0 in the following cycle.
  - An issue handshake in the flush cycle is still accepted downstream. The queue takes no further action on it.
- Tags compared at full TAG_W width. No wrap or arithmetic on tags.

Test Plan:
1. Reset, then dispatch op=3, rs1 ready=0x10, rs2 ready=0x20, rd_tag=5 with issue_ready=1 -> next cycle issue_valid=1, issue_op=3, issue_rs1=0x10, issue_rs2=0x20, issue_rd_tag=5; the following cycle issue_valid=0, count=0.
2. Dispatch rs1 tag=7 not ready, rs2 ready=1 -> issue_valid stays 0. CDB tag=7, data=0xABCD -> one cycle later issue_valid=1 with issue_rs1=0xABCD.
3. Dispatch rs1 tag=9 not ready in the same cycle that cdb_valid=1, cdb_tag=9, data=0x55 -> entry is stored ready and issues the next cycle with issue_rs1=0x55.
4. Issue_ready=0, dispatch 4 entries (DEPTH=4) -> full=1. A 5th dispatch is ignored. Issue_ready=1 for one cycle -> full=0, and the next issued rd_tag is the second-oldest entry.
5. Entries A (tag dependent on 3) and B (ready), dispatched in order A then B -> B issues first. CDB tag=3 -> A issues next. Confirms oldest-ready selection and age-preserving compaction.
6. Three entries queued with i_flush=1 and dispatch_en=1 in the same cycle -> next cycle count=0, full=0, issue_valid=0. Reset asserted mid-operation gives the same result.

Source files
------------

// File: rtl/int_issue_queue.sv
// ---------------------------------------------------------------------------
// int_issue_queue
//
// Integer reservation station sitting right after the dispatcher. Holds up to
// DEPTH instructions in a compacting queue (index 0 = oldest), snoops the CDB
// to wake pending operands, and presents the oldest fully-ready entry to the
// integer ALU through a valid/ready handshake.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_flush                 drop every entry (mispredict recovery)
//   dispatch_*              one new instruction per cycle; operand given as a
//                           value (rsN_valid=1) or as a producer tag
//   full                    registered; dispatcher must stall while set
//   cdb_valid/tag/data      result broadcast used for wakeup
//   issue_valid/ready       handshake towards the ALU
//   issue_op/rs1/rs2/rd_tag fields of the selected entry (zero when idle)
// ---------------------------------------------------------------------------
module int_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              dispatch_en,
    input  logic [OP_W-1:0]   dispatch_op,
    input  logic [DATA_W-1:0] dispatch_rs1_data,
    input  logic [TAG_W-1:0]  dispatch_rs1_tag,
    input  logic              dispatch_rs1_valid,
    input  logic [DATA_W-1:0] dispatch_rs2_data,
    input  logic [TAG_W-1:0]  dispatch_rs2_tag,
    input  logic              dispatch_rs2_valid,
    input  logic [TAG_W-1:0]  dispatch_rd_tag,
    output logic              full,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic              cdb_valid,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OP_W-1:0]   issue_op,
    output logic [DATA_W-1:0] issue_rs1,
    output logic [DATA_W-1:0] issue_rs2,
    output logic [TAG_W-1:0]  issue_rd_tag
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic              rs1_rdy;
        logic [TAG_W-1:0]  rs1_tag;
        logic [DATA_W-1:0] rs1_data;
        logic              rs2_rdy;
        logic [TAG_W-1:0]  rs2_tag;
        logic [DATA_W-1:0] rs2_data;
        logic [TAG_W-1:0]  rd_tag;
    } entry_t;

    // State
    logic [DEPTH-1:0] r_valid;
    entry_t           r_ent [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic             r_full;

    // Combinational
    logic             w_found;
    logic [IDX_W-1:0] w_sel_idx;
    logic [DEPTH-1:0] w_ge_sel;      // entry index is at or above the selected one
    logic [DEPTH-1:0] w_shift;       // entry takes its neighbour from above
    logic             w_fire;
    logic             w_disp;
    logic [CNT_W-1:0] w_wr_idx;
    logic [CNT_W-1:0] w_count_next;
    logic [DEPTH-1:0] w_src_valid;
    entry_t           w_src_ent   [DEPTH];
    logic [DEPTH-1:0] w_valid_next;
    entry_t           w_ent_next  [DEPTH];
    entry_t           w_new_ent;

    // Oldest-ready selection: first valid entry with both operands ready.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_ge_sel  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_found && r_valid[i] && r_ent[i].rs1_rdy && r_ent[i].rs2_rdy) begin
                w_found   = 1'b1;
                w_sel_idx = IDX_W'(i);
            end
            w_ge_sel[i] = w_found;
        end
    end

    assign w_fire  = w_found && issue_ready;
    assign w_shift = {DEPTH{w_fire}} & w_ge_sel;
    assign w_disp  = dispatch_en && !r_full && !i_flush;
    // A removal this cycle frees one slot below the current tail.
    assign w_wr_idx = r_count - CNT_W'(w_fire);

    // Compaction: every slot at or above the issued one pulls from slot+1.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
        if (gi < DEPTH - 1) begin : g_mid
            assign w_src_valid[gi] = w_shift[gi] ? r_valid[gi+1] : r_valid[gi];
            assign w_src_ent[gi]   = w_shift[gi] ? r_ent[gi+1]   : r_ent[gi];
        end else begin : g_top
            assign w_src_valid[gi] = w_shift[gi] ? 1'b0 : r_valid[gi];
            assign w_src_ent[gi]   = r_ent[gi];
        end
    end

    // New entry, with the same-cycle CDB bypass applied to pending operands.
    always_comb begin
        w_new_ent.op       = dispatch_op;
        w_new_ent.rd_tag   = dispatch_rd_tag;
        w_new_ent.rs1_tag  = dispatch_rs1_tag;
        w_new_ent.rs2_tag  = dispatch_rs2_tag;
        w_new_ent.rs1_rdy  = dispatch_rs1_valid;
        w_new_ent.rs1_data = dispatch_rs1_data;
        w_new_ent.rs2_rdy  = dispatch_rs2_valid;
        w_new_ent.rs2_data = dispatch_rs2_data;
        if (cdb_valid && !dispatch_rs1_valid && (cdb_tag == dispatch_rs1_tag)) begin
            w_new_ent.rs1_rdy  = 1'b1;
            w_new_ent.rs1_data = cdb_data;
        end
        if (cdb_valid && !dispatch_rs2_valid && (cdb_tag == dispatch_rs2_tag)) begin
            w_new_ent.rs2_rdy  = 1'b1;
            w_new_ent.rs2_data = cdb_data;
        end
    end

    // Wakeup is applied after the shift so an entry moving down still captures
    // the broadcast; then the dispatched entry lands at the tail.
    always_comb begin
        w_valid_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ent_next[i] = w_src_ent[i];
            if (cdb_valid && w_src_valid[i] && !w_src_ent[i].rs1_rdy
                && (w_src_ent[i].rs1_tag == cdb_tag)) begin
                w_ent_next[i].rs1_rdy  = 1'b1;
                w_ent_next[i].rs1_data = cdb_data;
            end
            if (cdb_valid && w_src_valid[i] && !w_src_ent[i].rs2_rdy
                && (w_src_ent[i].rs2_tag == cdb_tag)) begin
                w_ent_next[i].rs2_rdy  = 1'b1;
                w_ent_next[i].rs2_data = cdb_data;
            end
            w_valid_next[i] = w_src_valid[i];
            if (w_disp && (w_wr_idx == CNT_W'(i))) begin
                w_ent_next[i]   = w_new_ent;
                w_valid_next[i] = 1'b1;
            end
            if (i_flush) begin
                w_valid_next[i] = 1'b0;
            end
        end
    end

    assign w_count_next = i_flush ? '0
                        : (r_count + CNT_W'(w_disp) - CNT_W'(w_fire));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            r_valid <= w_valid_next;
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
        end
    end

    // Payload needs no reset: it is only observed through r_valid.
    always_ff @(posedge i_clk) begin
        r_ent <= w_ent_next;
    end

    assign full = r_full;

    always_comb begin
        issue_valid  = w_found;
        issue_op     = '0;
        issue_rs1    = '0;
        issue_rs2    = '0;
        issue_rd_tag = '0;
        if (w_found) begin
            issue_op     = r_ent[w_sel_idx].op;
            issue_rs1    = r_ent[w_sel_idx].rs1_data;
            issue_rs2    = r_ent[w_sel_idx].rs2_data;
            issue_rd_tag = r_ent[w_sel_idx].rd_tag;
        end
    end

endmodule

// File: tb/tb_int_issue_queue.sv
// ---------------------------------------------------------------------------
// Directed scoreboard bench for int_issue_queue (DEPTH=4). Expected issue
// transactions are queued when the stimulus is driven and compared when the
// ALU handshake occurs; directed checks cover idle/full/flush/reset states.
// ---------------------------------------------------------------------------
module tb_int_issue_queue;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    logic              clk = 1'b0;
    logic              rst, flush;
    logic              d_en, d_rs1_v, d_rs2_v;
    logic [OP_W-1:0]   d_op;
    logic [DATA_W-1:0] d_rs1_d, d_rs2_d;
    logic [TAG_W-1:0]  d_rs1_t, d_rs2_t, d_rd;
    logic              full;
    logic [TAG_W-1:0]  cdb_tag;
    logic              cdb_valid;
    logic [DATA_W-1:0] cdb_data;
    logic              issue_valid, issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_rs1, issue_rs2;
    logic [TAG_W-1:0]  issue_rd_tag;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
        logic [TAG_W-1:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_flush            (flush),
        .dispatch_en        (d_en),
        .dispatch_op        (d_op),
        .dispatch_rs1_data  (d_rs1_d),
        .dispatch_rs1_tag   (d_rs1_t),
        .dispatch_rs1_valid (d_rs1_v),
        .dispatch_rs2_data  (d_rs2_d),
        .dispatch_rs2_tag   (d_rs2_t),
        .dispatch_rs2_valid (d_rs2_v),
        .dispatch_rd_tag    (d_rd),
        .full               (full),
        .cdb_tag            (cdb_tag),
        .cdb_valid          (cdb_valid),
        .cdb_data           (cdb_data),
        .issue_valid        (issue_valid),
        .issue_ready        (issue_ready),
        .issue_op           (issue_op),
        .issue_rs1          (issue_rs1),
        .issue_rs2          (issue_rs2),
        .issue_rd_tag       (issue_rd_tag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue outputs depend only on registered state, so sampling 1 time unit
    // after the previous edge sees the values the next edge will act on.
    task automatic tick();
        exp_t e;
        if (issue_valid && issue_ready) begin
            if (sb.size() == 0) begin
                check("issue_unexpected", {31'd0, issue_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("issue: op=%h rs1=%h rs2=%h rd=%h", issue_op, issue_rs1, issue_rs2, issue_rd_tag);
                check("issue_op",  32'(issue_op),     32'(e.op));
                check("issue_rs1", issue_rs1,         e.rs1);
                check("issue_rs2", issue_rs2,         e.rs2);
                check("issue_rd",  32'(issue_rd_tag), 32'(e.rd));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [OP_W-1:0] op,
                        input logic r1v, input logic [TAG_W-1:0] r1t, input logic [DATA_W-1:0] r1d,
                        input logic r2v, input logic [TAG_W-1:0] r2t, input logic [DATA_W-1:0] r2d,
                        input logic [TAG_W-1:0] rd);
        d_en = 1'b1; d_op = op;
        d_rs1_v = r1v; d_rs1_t = r1t; d_rs1_d = r1d;
        d_rs2_v = r2v; d_rs2_t = r2t; d_rs2_d = r2d;
        d_rd = rd;
    endtask

    task automatic push(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] r1,
                        input logic [DATA_W-1:0] r2, input logic [TAG_W-1:0] rd);
        exp_t e;
        e.op = op; e.rs1 = r1; e.rs2 = r2; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic cdb(input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdb_valid = v; cdb_tag = t; cdb_data = d;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; d_en = 1'b0; d_op = '0;
        d_rs1_v = 1'b0; d_rs1_t = '0; d_rs1_d = '0;
        d_rs2_v = 1'b0; d_rs2_t = '0; d_rs2_d = '0; d_rd = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
        @(posedge clk); #1;
        tick();
        rst = 1'b0;
        check("rst_full",  32'(full),         32'd0);
        check("rst_valid", 32'(issue_valid),  32'd0);
        check("rst_op",    32'(issue_op),     32'd0);
        check("rst_rs1",   issue_rs1,         32'd0);
        check("rst_rs2",   issue_rs2,         32'd0);
        check("rst_rd",    32'(issue_rd_tag), 32'd0);

        // 1: ready instruction issues one cycle after dispatch
        issue_ready = 1'b1;
        disp(4'd3, 1'b1, 6'd0, 32'h10, 1'b1, 6'd0, 32'h20, 6'd5);
        push(4'd3, 32'h10, 32'h20, 6'd5);
        tick();
        d_en = 1'b0;
        check("t1_valid", 32'(issue_valid),  32'd1);
        check("t1_op",    32'(issue_op),     32'd3);
        check("t1_rd",    32'(issue_rd_tag), 32'd5);
        tick();
        check("t1_empty", 32'(issue_valid), 32'd0);
        check("t1_full",  32'(full),        32'd0);

        // 2: wakeup from CDB
        disp(4'd1, 1'b0, 6'd7, 32'h0, 1'b1, 6'd0, 32'h2, 6'd6);
        tick();
        d_en = 1'b0;
        check("t2_wait", 32'(issue_valid), 32'd0);
        cdb(1'b1, 6'd7, 32'hABCD);
        push(4'd1, 32'hABCD, 32'h2, 6'd6);
        tick();
        cdb(1'b0, 6'd0, 32'h0);
        check("t2_woke", 32'(issue_valid), 32'd1);
        check("t2_rs1",  issue_rs1,        32'hABCD);
        tick();
        check("t2_empty", 32'(issue_valid), 32'd0);

        // 3: dispatch-time bypass
        disp(4'd2, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'h3, 6'd7);
        cdb(1'b1, 6'd9, 32'h55);
        push(4'd2, 32'h55, 32'h3, 6'd7);
        tick();
        d_en = 1'b0; cdb(1'b0, 6'd0, 32'h0);
        check("t3_valid", 32'(issue_valid), 32'd1);
        check("t3_rs1",   issue_rs1,        32'h55);
        tick();

        // 4: fill to full, reject 5th, drain
        issue_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            disp(4'(i), 1'b1, 6'd0, 32'(i + 100), 1'b1, 6'd0, 32'(i + 200), 6'(10 + i));
            push(4'(i), 32'(i + 100), 32'(i + 200), 6'(10 + i));
            tick();
        end
        check("t4_full", 32'(full), 32'd1);
        disp(4'hF, 1'b1, 6'd0, 32'hDEAD, 1'b1, 6'd0, 32'hBEEF, 6'd14);
        tick();
        d_en = 1'b0;
        check("t4_still_full", 32'(full),         32'd1);
        check("t4_oldest",     32'(issue_rd_tag), 32'd10);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        check("t4_not_full", 32'(full),         32'd0);
        check("t4_second",   32'(issue_rd_tag), 32'd11);
        issue_ready = 1'b1;
        tick(); tick(); tick();
        check("t4_drained", 32'(issue_valid), 32'd0);

        // 5: younger ready entry bypasses older waiting one
        issue_ready = 1'b0;
        disp(4'd5, 1'b0, 6'd3, 32'h0, 1'b1, 6'd0, 32'h7, 6'd20);
        tick();
        disp(4'd6, 1'b1, 6'd0, 32'h8, 1'b1, 6'd0, 32'h9, 6'd21);
        push(4'd6, 32'h8, 32'h9, 6'd21);
        tick();
        d_en = 1'b0;
        check("t5_b_first", 32'(issue_rd_tag), 32'd21);
        issue_ready = 1'b1;
        tick();
        check("t5_a_wait", 32'(issue_valid), 32'd0);
        cdb(1'b1, 6'd3, 32'h33);
        push(4'd5, 32'h33, 32'h7, 6'd20);
        tick();
        cdb(1'b0, 6'd0, 32'h0);
        check("t5_a_rd", 32'(issue_rd_tag), 32'd20);
        tick();
        check("t5_empty", 32'(issue_valid), 32'd0);

        // 5b: issue + shift + wakeup + dispatch in one cycle
        issue_ready = 1'b0;
        disp(4'd1, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2, 6'd30);
        push(4'd1, 32'h1, 32'h2, 6'd30);
        tick();
        disp(4'd2, 1'b1, 6'd0, 32'h3, 1'b0, 6'd4, 32'h0, 6'd31);
        tick();
        issue_ready = 1'b1;
        cdb(1'b1, 6'd4, 32'h44);
        push(4'd2, 32'h3, 32'h44, 6'd31);
        disp(4'd3, 1'b1, 6'd0, 32'h5, 1'b1, 6'd0, 32'h6, 6'd32);
        push(4'd3, 32'h5, 32'h6, 6'd32);
        tick();
        d_en = 1'b0; cdb(1'b0, 6'd0, 32'h0);
        check("t5b_shift_woke", 32'(issue_rd_tag), 32'd31);
        tick(); tick();
        check("t5b_empty", 32'(issue_valid), 32'd0);

        // 6: flush with concurrent dispatch, then reset mid-operation
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(4'd7, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 6'(40 + i));
            tick();
        end
        check("t6_pre_valid", 32'(issue_valid), 32'd1);
        flush = 1'b1;
        disp(4'd8, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 6'd43);
        tick();
        flush = 1'b0; d_en = 1'b0;
        check("t6_flush_valid", 32'(issue_valid),  32'd0);
        check("t6_flush_full",  32'(full),         32'd0);
        check("t6_flush_rd",    32'(issue_rd_tag), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            disp(4'd9, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 6'(50 + i));
            tick();
        end
        d_en = 1'b0;
        check("t6_refill_full", 32'(full), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", 32'(issue_valid), 32'd0);
        check("t6_rst_full",  32'(full),        32'd0);
        check("t6_rst_op",    32'(issue_op),    32'd0);

        // queue usable after reset
        issue_ready = 1'b1;
        disp(4'd4, 1'b1, 6'd0, 32'h77, 1'b1, 6'd0, 32'h88, 6'd60);
        push(4'd4, 32'h77, 32'h88, 6'd60);
        tick();
        d_en = 1'b0;
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
